// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic.
// Register-zero constant, mult/div tracker states and default latencies.
package mips_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks an in-flight multi-cycle multiply/divide operation.
// Busy for LAT-1 cycles after issue, then a one-cycle done pulse.
module md_busy_tracker
  import mips_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_done
);

  md_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // A start while busy is ignored; Decode stalls prevent it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = i_is_div ? CNT_W'(DIV_LAT - 2)
                                 : CNT_W'(MULT_LAT - 2);
        end
      end
      MD_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy = (r_state == MD_BUSY);
  assign o_done = r_done;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control and Decode branch forwarding for the 5-stage MIPS pipe.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter.
module hazard_stall_unit
  import mips_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        MdStartE,
  input  logic        MdIsDivE,
  input  logic        MdUseD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        MdBusy,
  output logic        MdDone,
  output logic [31:0] StallCycles
);

  logic w_lwstall, w_brstall, w_mdstall, w_stall;
  logic w_e_hit, w_m_hit;
  logic w_unused;

  // rsE belongs to the E-stage forwarding path, not to stalls.
  assign w_unused = ^rsE;

  assign ForwardAD = RegWriteM & (rsD != REG_ZERO)
                   & (rsD == WriteRegM);
  assign ForwardBD = RegWriteM & (rtD != REG_ZERO)
                   & (rtD == WriteRegM);

  assign w_lwstall = MemtoRegE & (rtE != REG_ZERO)
                   & ((rtE == rsD) | (rtE == rtD));

  assign w_e_hit = RegWriteE & (WriteRegE != REG_ZERO)
                 & ((WriteRegE == rsD) | (WriteRegE == rtD));
  assign w_m_hit = MemtoRegM & (WriteRegM != REG_ZERO)
                 & ((WriteRegM == rsD) | (WriteRegM == rtD));
  assign w_brstall = BranchD & (w_e_hit | w_m_hit);

  assign w_mdstall = MdUseD & (MdBusy | MdStartE);

  assign w_stall = w_lwstall | w_brstall | w_mdstall;
  assign StallF  = w_stall;
  assign StallD  = w_stall;
  assign FlushE  = w_stall;

  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md (
    .clk      (clk),
    .reset    (reset),
    .i_start  (MdStartE),
    .i_is_div (MdIsDivE),
    .o_busy   (MdBusy),
    .o_done   (MdDone)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign StallCycles = r_stall_cnt;
`else
  assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and randomized bench for hazard_stall_unit.
// Reference model tracks mult/div by busy-cycle windows.
module tb_hazard_stall_unit;

  localparam int ML = 4;
  localparam int DL = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM;
  logic        RegWriteE, RegWriteM, MemtoRegE, MemtoRegM;
  logic        BranchD, MdStartE, MdIsDivE, MdUseD;
  logic        StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic        MdBusy, MdDone;
  logic [31:0] StallCycles;

  int checks = 0;
  int errors = 0;

  // model state: absolute cycle numbers
  int          cyc     = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  int          done_c  = -1;
  logic [31:0] perf    = '0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .MdStartE(MdStartE),
    .MdIsDivE(MdIsDivE), .MdUseD(MdUseD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MdBusy(MdBusy), .MdDone(MdDone),
    .StallCycles(StallCycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  task automatic clr();
    reset = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    WriteRegE = 0; WriteRegM = 0;
    RegWriteE = 0; RegWriteM = 0; MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; MdStartE = 0; MdIsDivE = 0; MdUseD = 0;
  endtask

  // check current cycle against the model, then advance one clock
  task automatic tick();
    bit busy, lw, br, md, st, fa, fb;
    logic [31:0] pexp;
    #3;
    busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    lw = MemtoRegE && (hit(rtE, rsD) || hit(rtE, rtD));
    br = BranchD &&
         ((RegWriteE && (hit(WriteRegE, rsD) || hit(WriteRegE, rtD))) ||
          (MemtoRegM && (hit(WriteRegM, rsD) || hit(WriteRegM, rtD))));
    md = MdUseD && (busy || MdStartE);
    st = lw || br || md;
    fa = RegWriteM && hit(WriteRegM, rsD);
    fb = RegWriteM && hit(WriteRegM, rtD);
`ifdef HAZARD_PERF_EN
    pexp = perf;
`else
    pexp = 32'd0;
`endif
    chk("StallF", {31'd0, StallF}, {31'd0, st});
    chk("StallD", {31'd0, StallD}, {31'd0, st});
    chk("FlushE", {31'd0, FlushE}, {31'd0, st});
    chk("ForwardAD", {31'd0, ForwardAD}, {31'd0, fa});
    chk("ForwardBD", {31'd0, ForwardBD}, {31'd0, fb});
    chk("MdBusy", {31'd0, MdBusy}, {31'd0, busy});
    chk("MdDone", {31'd0, MdDone}, {31'd0, (cyc == done_c)});
    chk("StallCycles", StallCycles, pexp);
    if (MdStartE && !reset)
      chk("start_while_busy", {31'd0, MdBusy}, 32'd0);
    if (reset) begin
      perf = '0;
      if (busy_hi > cyc) busy_hi = cyc;
      if (done_c > cyc) done_c = -1;
    end else begin
      if (st && perf != 32'hFFFF_FFFF) perf = perf + 1;
      if (MdStartE && !busy) begin
        busy_lo = cyc + 1;
        busy_hi = cyc + (MdIsDivE ? DL : ML) - 1;
        done_c  = cyc + (MdIsDivE ? DL : ML);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    clr();
    reset = 1;
    @(posedge clk);
    #1;
    tick();
    tick();

    // load-use
    clr(); MemtoRegE = 1; rtE = 8; rsD = 8; tick();
    rsD = 9; rtD = 3; tick();
    rtE = 0; rsD = 0; rtD = 0; tick();

    // branch compare
    clr(); BranchD = 1; RegWriteE = 1; WriteRegE = 5; rtD = 5; tick();
    RegWriteE = 0; RegWriteM = 1; WriteRegM = 5; tick();
    MemtoRegM = 1; tick();

    // multiply, uses during cycles 1-4
    clr(); MdStartE = 1; tick();
    clr(); MdUseD = 1;
    for (int i = 0; i < 4; i++) tick();
    clr();
    chk("mul_done_gone", {31'd0, MdDone}, 32'd0);

    // divide with same-cycle use
    MdStartE = 1; MdIsDivE = 1; MdUseD = 1; tick();
    clr(); MdUseD = 1;
    for (int i = 0; i < 32; i++) tick();
    clr(); tick();

    // reset mid-divide
    MdStartE = 1; MdIsDivE = 1; tick();
    clr();
    for (int i = 0; i < 9; i++) tick();
    reset = 1; tick();
    clr();
    chk("abort_busy", {31'd0, MdBusy}, 32'd0);
    for (int i = 0; i < 30; i++) tick();

    // perf: 3 load-use + 31 divide stalls
    reset = 1; tick();
    clr(); MemtoRegE = 1; rtE = 8; rsD = 8;
    for (int i = 0; i < 3; i++) tick();
    clr(); MdStartE = 1; MdIsDivE = 1; tick();
    clr(); MdUseD = 1;
    for (int i = 0; i < 31; i++) tick();
    clr();
`ifdef HAZARD_PERF_EN
    chk("perf_total", StallCycles, 32'd34);
`else
    chk("perf_total", StallCycles, 32'd0);
`endif
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit busy_now;
      busy_now = (cyc >= busy_lo) && (cyc <= busy_hi);
      reset     = ($urandom_range(0, 49) == 0);
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      rsE       = 5'($urandom_range(0, 3));
      rtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      MemtoRegM = ($urandom_range(0, 3) == 0);
      BranchD   = ($urandom_range(0, 2) == 0);
      MdIsDivE  = ($urandom_range(0, 3) == 0);
      MdUseD    = ($urandom_range(0, 2) == 0);
      MdStartE  = !busy_now && ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
